// File: rtl/mem_wishbone_master_pkg.sv
// Shared definitions for the MEM-stage Wishbone data port: RV32 load/store
// size encodings, bus FSM states and a funct3 size decoder.
package mem_wishbone_master_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {WB_IDLE, WB_BUS, WB_RESP} wb_state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

  // Any encoding that is not a byte or halfword access behaves as a word.
  function automatic acc_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: select/write-data placement and
// misalignment on the request side, lane extraction and extension on the response side.
module mem_lane_align
  import mem_wishbone_master_pkg::*;
(
  input  logic [1:0]  acc_addr_lo,
  input  logic [2:0]  acc_funct3,
  input  logic [31:0] acc_wdata,
  output logic [3:0]  acc_sel,
  output logic [31:0] acc_wdata_lanes,
  output logic        acc_misaligned,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [2:0]  rsp_funct3,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_unsigned;

  always_comb begin
    acc_sel         = 4'b1111;
    acc_wdata_lanes = acc_wdata;
    acc_misaligned  = 1'b0;
    case (f3_size(acc_funct3))
      SZ_BYTE: begin
        acc_sel         = 4'b0001 << acc_addr_lo;
        acc_wdata_lanes = {4{acc_wdata[7:0]}};
      end
      SZ_HALF: begin
        acc_sel         = 4'b0011 << acc_addr_lo;
        acc_wdata_lanes = {2{acc_wdata[15:0]}};
        acc_misaligned  = acc_addr_lo[0];
      end
      default: acc_misaligned = |acc_addr_lo;
    endcase
  end

  // Halfword loads are aligned by construction, so only addr bit 1 picks the half.
  always_comb begin
    case (rsp_addr_lo)
      2'd0:    ld_byte = rsp_rdata[7:0];
      2'd1:    ld_byte = rsp_rdata[15:8];
      2'd2:    ld_byte = rsp_rdata[23:16];
      default: ld_byte = rsp_rdata[31:24];
    endcase
    ld_half     = rsp_addr_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    ld_unsigned = (rsp_funct3 == F3_LBU) || (rsp_funct3 == F3_LHU);
    case (f3_size(rsp_funct3))
      SZ_BYTE: rsp_load_data = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: rsp_load_data = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: rsp_load_data = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wishbone_master.sv
// MEM-stage data-memory port: one load/store becomes one Wishbone B4 classic
// cycle, with stall handshake to the hazard unit and fault reporting to trap logic.
module mem_wishbone_master
  import mem_wishbone_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid,
  input  logic                  mem_rd_en,
  input  logic                  mem_wr_en,
  input  logic [2:0]            mem_funct3,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic                  mem_trap_valid,
  output logic                  wishbone_req,
  output logic                  wishbone_done,
  output logic [31:0]           load_rdata,
  output logic                  misaligned,
  output logic                  access_fault,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  wb_state_t             state_q, state_d;
  logic                  cyc_q, we_q, fault_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [31:0]           dat_q, rdata_q;
  logic [3:0]            sel_q;
  logic [1:0]            lo_q;
  logic [2:0]            f3_q;
  logic [CNT_W-1:0]      tmo_cnt_q;

  logic                  mem_access, access_req, timeout_hit, bus_end, bus_fault;
  logic                  acc_misaligned;
  logic [3:0]            acc_sel;
  logic [31:0]           acc_wdata_lanes, rsp_load_data;
  logic [ADDR_WIDTH-1:0] adr_word;

  mem_lane_align u_align (
    .acc_addr_lo     (mem_addr[1:0]),
    .acc_funct3      (mem_funct3),
    .acc_wdata       (mem_wdata),
    .acc_sel         (acc_sel),
    .acc_wdata_lanes (acc_wdata_lanes),
    .acc_misaligned  (acc_misaligned),
    .rsp_addr_lo     (lo_q),
    .rsp_funct3      (f3_q),
    .rsp_rdata       (wb_dat_i),
    .rsp_load_data   (rsp_load_data)
  );

  assign mem_access  = mem_valid & (mem_rd_en | mem_wr_en);
  assign misaligned  = mem_access & acc_misaligned;
  assign access_req  = mem_access & ~mem_trap_valid & ~acc_misaligned;
  assign adr_word    = ADDR_WIDTH'({mem_addr[31:2], 2'b00});
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == CNT_W'(TMO_LAST));
  // A response arriving on the last allowed cycle still counts; ERR beats ACK.
  assign bus_end     = wb_ack_i | wb_err_i | timeout_hit;
  assign bus_fault   = wb_err_i | (timeout_hit & ~wb_ack_i);

  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;
  assign load_rdata   = wishbone_done ? rdata_q : '0;
  assign access_fault = wishbone_done & fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    wishbone_req  = 1'b0;
    wishbone_done = 1'b0;
    case (state_q)
      WB_IDLE: begin
        wishbone_req = access_req;
        if (access_req) state_d = WB_BUS;
      end
      WB_BUS: begin
        wishbone_req = 1'b1;
        if (bus_end) state_d = WB_RESP;
      end
      WB_RESP: begin
        wishbone_req  = 1'b1;
        wishbone_done = 1'b1;
        state_d       = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Bus-facing registers are cleared when the cycle ends so the bus idles at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      lo_q      <= '0;
      f3_q      <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (access_req) begin
            cyc_q     <= 1'b1;
            we_q      <= mem_wr_en;
            adr_q     <= adr_word;
            dat_q     <= mem_wr_en ? acc_wdata_lanes : '0;
            sel_q     <= acc_sel;
            lo_q      <= mem_addr[1:0];
            f3_q      <= mem_funct3;
            tmo_cnt_q <= '0;
          end
        end
        WB_BUS: begin
          if (bus_end) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            fault_q <= bus_fault;
            rdata_q <= (we_q | bus_fault) ? '0 : rsp_load_data;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_wishbone_master.md
Name: mem_wishbone_master

Overview:
MEM-stage data-memory port. Turns one load/store in MEM into a single Wishbone B4 classic bus cycle. It generates the WISHBONE_REQ/WISHBONE_DONE pair that the hazard unit uses to stall the pipeline. It also handles byte-lane alignment, load extension, misalignment detection and bus error/timeout reporting toward the trap logic.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for ACK/ERR after STB; 0 disables timeout
ADDR_WIDTH, 32, Wishbone address width

Ports:
CLK  in  1  core clock; all state updates on rising edge
RST_N  in  1  synchronous active-low reset, sampled on rising CLK
MEM_VALID  in  1  valid instruction in MEM stage
MEM_RD_EN  in  1  instruction is a load
MEM_WR_EN  in  1  instruction is a store
MEM_FUNCT3  in  3  RV32 size/sign: LB/LH/LW/LBU/LHU, SB/SH/SW
MEM_ADDR  in  32  effective byte address
MEM_WDATA  in  32  store data, right-aligned
MEM_TRAP_VALID  in  1  MEM instruction already trapping; suppresses access
WISHBONE_REQ  out  1  access in progress or completing (to hazard unit)
WISHBONE_DONE  out  1  one-cycle completion pulse (to hazard unit)
LOAD_RDATA  out  32  extended load result, valid while WISHBONE_DONE
MISALIGNED  out  1  combinational: misaligned access, no bus cycle
ACCESS_FAULT  out  1  with WISHBONE_DONE: ERR_I or timeout ended the cycle
WB_CYC_O  out  1  bus cycle
WB_STB_O  out  1  strobe
WB_WE_O  out  1  write enable
WB_ADR_O  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
WB_DAT_O  out  32  lane-positioned write data
WB_SEL_O  out  4  byte selects
WB_DAT_I  in  32  read data
WB_ACK_I  in  1  acknowledge
WB_ERR_I  in  1  error

Behaviour:
- access_req = MEM_VALID & (MEM_RD_EN | MEM_WR_EN) & ~MEM_TRAP_VALID & ~MISALIGNED.
- MISALIGNED: halfword with ADDR[0]=1, or word with ADDR[1:0]!=0, gated by MEM_VALID & (RD|WR). Invalid funct3 is treated as word.
- FSM states: IDLE, BUS, RESP.
- IDLE: WISHBONE_REQ = access_req (combinational). If access_req: register WE/ADR/SEL/DAT_O; next state BUS.
- BUS: WB_CYC_O = WB_STB_O = 1 (registered outputs, rise the cycle after IDLE accepts). WISHBONE_REQ = 1.
  - ACK_I or ERR_I: capture WB_DAT_I and fault flag; drop CYC/STB at the next edge; next state RESP.
  - ACK and ERR in the same cycle: ERR wins.
- RESP: WISHBONE_REQ = 1, WISHBONE_DONE = 1, LOAD_RDATA valid, ACCESS_FAULT = captured flag. Next state IDLE unconditionally. The pipeline advances at the end of this cycle, so no access is reissued.
- Minimum latency: request in cycle N, ACK in N+1, DONE in N+2. Stall (REQ & ~DONE) covers cycles N and N+1.
- Timeout: counter clears on entry to BUS and increments each BUS cycle. When count == TIMEOUT_CYCLES-1 with no ACK/ERR: abort as ERR (CYC/STB drop, RESP with ACCESS_FAULT=1). With TIMEOUT_CYCLES=0 the counter is inactive.
- MEM_TRAP_VALID and MEM_* inputs are sampled only in IDLE. A started bus cycle always runs to ACK/ERR/timeout.
- Store lanes:
  - SB: SEL = 0001<<ADDR[1:0], byte replicated ×4.
  - SH: SEL = 0011<<ADDR[1:0], halfword replicated ×2.
  - SW: SEL = 1111.
- Loads: SEL by size as for stores. Extract lane by ADDR[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU. LOAD_RDATA = 0 when the captured access was a store or faulted.
- Reset (RST_N low at edge, including mid-BUS): state IDLE; CYC/STB/WE = 0; ADR/DAT_O/SEL = 0; captured data 0; timeout counter 0. WISHBONE_DONE = 0 and ACCESS_FAULT = 0 after reset. WISHBONE_REQ follows access_req combinationally in IDLE.
- All outputs drive zero when inactive; no X.

Decomposition:
- Shared package: funct3 load/store size constants (LB..LHU, SB..SW); wb_state_t enum {WB_IDLE, WB_BUS, WB_RESP}.
- One combinational sub-module, mem_lane_align:
  - store path: ADDR[1:0] + funct3 + wdata → SEL/DAT_O + misaligned.
  - load path: ADDR[1:0] + funct3 + DAT_I → extended data.
- FSM, counter and bus registers stay in the top module.

Test Plan:
- LW at 0x1000, slave returns 0xDEADBEEF with ACK 1 cycle after STB → REQ high 3 cycles; DONE in third; LOAD_RDATA=0xDEADBEEF; ADR=0x1000; SEL=1111; WE=0.
- LB at 0x1003, DAT_I=0x80FF_FF_FF → LOAD_RDATA=0xFFFFFF80. LBU at same address → 0x00000080.
- SH at 0x2002, WDATA=0x1234ABCD → WE=1; SEL=1100; DAT_O=0xABCDABCD; DONE after ACK; LOAD_RDATA=0.
- LW at 0x3001 → MISALIGNED=1; REQ=0; CYC never asserted. SH at 0x3001 → same.
- TIMEOUT_CYCLES=4, slave never acks → CYC high exactly 4 cycles, then DONE with ACCESS_FAULT=1. A separate case with ERR_I and ACK_I together → fault wins.
- RST_N low during BUS → next cycle CYC=STB=0 and state IDLE. A new LW after reset completes normally. MEM_TRAP_VALID=1 with a load → REQ=0 and no bus cycle.
